// File: rtl/reg_file_sb.sv
// Register file with a per-register scoreboard (busy bit), two combinational read ports,
// one write port and one reservation port. Optional write-to-read bypass: REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] RaddrA,
  input  logic [ADDR_W-1:0] RaddrB,
  output logic [DATA_W-1:0] DataOutA,
  output logic [DATA_W-1:0] DataOutB,
  input  logic              ReserveEn,
  input  logic [ADDR_W-1:0] ReserveAddr,
  output logic              ReserveAck,
  output logic              BusyA,
  output logic              BusyB,
  output logic              AnyBusy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } busy_state_e;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  busy_state_e       busy_q [DEPTH];
  busy_state_e       busy_d [DEPTH];
  logic              any_busy_q;
  logic              any_busy_d;
  logic              wr_ok;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr_ok      = WriteEn & ~Reset & ~is_zero_reg(Waddr);
  assign ReserveAck = ReserveEn & ~Reset & (busy_q[ReserveAddr] == IDLE)
                      & ~is_zero_reg(ReserveAddr);
  assign AnyBusy    = any_busy_q;

  // Next state: reset wins over everything; otherwise an accepted reserve beats a write.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    any_busy_d = 1'b0;
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
        busy_d[i] = IDLE;
      end
    end else begin
      if (wr_ok) regs_d[Waddr] = DataIn;
      for (int i = 0; i < DEPTH; i++) begin
        case (busy_q[i])
          IDLE:    if (ReserveAck && (ReserveAddr == ADDR_W'(i))) busy_d[i] = PENDING;
          PENDING: if (WriteEn && (Waddr == ADDR_W'(i)))          busy_d[i] = IDLE;
          default: busy_d[i] = IDLE;
        endcase
      end
    end
    for (int i = 0; i < DEPTH; i++) any_busy_d = any_busy_d | (busy_d[i] == PENDING);
  end

  always_ff @(posedge Clk) begin
    regs_q     <= regs_d;
    busy_q     <= busy_d;
    any_busy_q <= any_busy_d;
  end

  always_comb begin
    DataOutA = regs_q[RaddrA];
    BusyA    = (busy_q[RaddrA] == PENDING);
    if (is_zero_reg(RaddrA)) begin
      DataOutA = '0;
      BusyA    = 1'b0;
    end
`ifdef REG_FILE_SB_BYPASS_EN
    // A same-cycle write releases the reservation unless it is re-reserved right now.
    if (wr_ok && (Waddr == RaddrA)) begin
      DataOutA = DataIn;
      BusyA    = ReserveAck && (ReserveAddr == RaddrA);
    end
`endif
  end

  always_comb begin
    DataOutB = regs_q[RaddrB];
    BusyB    = (busy_q[RaddrB] == PENDING);
    if (is_zero_reg(RaddrB)) begin
      DataOutB = '0;
      BusyB    = 1'b0;
    end
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_ok && (Waddr == RaddrB)) begin
      DataOutB = DataIn;
      BusyB    = ReserveAck && (ReserveAddr == RaddrB);
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with default parameters, one with ZERO_REG=1.
module tb_reg_file_sb;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       WriteEn, ReserveEn;
  logic [1:0] Waddr, RaddrA, RaddrB, ReserveAddr;
  logic [7:0] DataIn;
  logic [7:0] DataOutA, DataOutB;
  logic       ReserveAck, BusyA, BusyB, AnyBusy;

  logic       z_WriteEn, z_ReserveEn;
  logic [1:0] z_Waddr, z_RaddrA, z_RaddrB, z_ReserveAddr;
  logic [7:0] z_DataIn;
  logic [7:0] z_DataOutA, z_DataOutB;
  logic       z_ReserveAck, z_BusyA, z_BusyB, z_AnyBusy;

  int errors = 0;
  int checks = 0;
  bit bypass;

  always #5 Clk = ~Clk;

  reg_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(DataOutA), .DataOutB(DataOutB),
    .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr), .ReserveAck(ReserveAck),
    .BusyA(BusyA), .BusyB(BusyB), .AnyBusy(AnyBusy)
  );

  reg_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
    .Clk(Clk), .Reset(Reset), .WriteEn(z_WriteEn), .Waddr(z_Waddr), .DataIn(z_DataIn),
    .RaddrA(z_RaddrA), .RaddrB(z_RaddrB), .DataOutA(z_DataOutA), .DataOutB(z_DataOutB),
    .ReserveEn(z_ReserveEn), .ReserveAddr(z_ReserveAddr), .ReserveAck(z_ReserveAck),
    .BusyA(z_BusyA), .BusyB(z_BusyB), .AnyBusy(z_AnyBusy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    WriteEn = 0; ReserveEn = 0; Waddr = 0; ReserveAddr = 0; DataIn = 0;
  endtask

  initial begin
`ifdef REG_FILE_SB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    idle_inputs();
    RaddrA = 0; RaddrB = 0;
    z_WriteEn = 0; z_ReserveEn = 0; z_Waddr = 0; z_ReserveAddr = 0; z_DataIn = 0;
    z_RaddrA = 0; z_RaddrB = 0;
    Reset = 1;
    tick();
    tick();
    // Ack must stay low while reset is asserted
    ReserveEn = 1; ReserveAddr = 1;
    #1 check("ack_in_reset", {7'd0, ReserveAck}, 8'h00);
    tick();
    Reset = 0;
    idle_inputs();

    for (int a = 0; a < 4; a++) begin
      RaddrA = 2'(a); RaddrB = 2'(a);
      #1;
      check($sformatf("rst_dataA_r%0d", a), DataOutA, 8'h00);
      check($sformatf("rst_dataB_r%0d", a), DataOutB, 8'h00);
      check($sformatf("rst_busyA_r%0d", a), {7'd0, BusyA}, 8'h00);
      check($sformatf("rst_busyB_r%0d", a), {7'd0, BusyB}, 8'h00);
    end
    check("rst_anybusy", {7'd0, AnyBusy}, 8'h00);

    // Write 0x5A to r2
    WriteEn = 1; Waddr = 2; DataIn = 8'h5A; RaddrA = 2; RaddrB = 2;
    #1 check("wr_cycle_r2_A", DataOutA, bypass ? 8'h5A : 8'h00);
    tick();
    idle_inputs();
    #1;
    check("rd_r2_A", DataOutA, 8'h5A);
    check("rd_r2_B", DataOutB, 8'h5A);
    RaddrB = 1;
    #1 check("r1_hold", DataOutB, 8'h00);

    // Reserve r1, re-reserve rejected, write releases
    ReserveEn = 1; ReserveAddr = 1; RaddrA = 1;
    #1 check("rsv_r1_ack", {7'd0, ReserveAck}, 8'h01);
    tick();
    idle_inputs();
    #1;
    check("rsv_r1_busyA", {7'd0, BusyA}, 8'h01);
    check("rsv_r1_anybusy", {7'd0, AnyBusy}, 8'h01);
    ReserveEn = 1; ReserveAddr = 1;
    #1 check("rsv_r1_again_ack", {7'd0, ReserveAck}, 8'h00);
    tick();
    idle_inputs();
    #1 check("rsv_r1_still_busy", {7'd0, BusyA}, 8'h01);
    WriteEn = 1; Waddr = 1; DataIn = 8'h33;
    #1 check("wr_r1_cycle_busyA", {7'd0, BusyA}, bypass ? 8'h00 : 8'h01);
    tick();
    idle_inputs();
    #1;
    check("wr_r1_busyA", {7'd0, BusyA}, 8'h00);
    check("wr_r1_data", DataOutA, 8'h33);
    check("wr_r1_anybusy", {7'd0, AnyBusy}, 8'h00);

    // Write and reserve same address: set wins
    WriteEn = 1; Waddr = 3; DataIn = 8'h11; ReserveEn = 1; ReserveAddr = 3; RaddrA = 3;
    #1;
    check("wr_rsv_r3_ack", {7'd0, ReserveAck}, 8'h01);
    check("wr_rsv_r3_cycle_data", DataOutA, bypass ? 8'h11 : 8'h00);
    check("wr_rsv_r3_cycle_busy", {7'd0, BusyA}, bypass ? 8'h01 : 8'h00);
    tick();
    idle_inputs();
    #1;
    check("wr_rsv_r3_data", DataOutA, 8'h11);
    check("wr_rsv_r3_busy", {7'd0, BusyA}, 8'h01);
    check("wr_rsv_r3_anybusy", {7'd0, AnyBusy}, 8'h01);

    // Write r1 and reserve r0 in the same cycle: independent
    WriteEn = 1; Waddr = 1; DataIn = 8'h77; ReserveEn = 1; ReserveAddr = 0;
    RaddrA = 1; RaddrB = 0;
    #1 check("split_ack_r0", {7'd0, ReserveAck}, 8'h01);
    tick();
    idle_inputs();
    #1;
    check("split_r1_data", DataOutA, 8'h77);
    check("split_r1_busy", {7'd0, BusyA}, 8'h00);
    check("split_r0_busy", {7'd0, BusyB}, 8'h01);

    // Reserve r2, then reset with a concurrent write and reserve
    ReserveEn = 1; ReserveAddr = 2;
    #1 check("rsv_r2_ack", {7'd0, ReserveAck}, 8'h01);
    tick();
    Reset = 1; WriteEn = 1; Waddr = 2; DataIn = 8'hFF; ReserveEn = 1; ReserveAddr = 1;
    #1 check("rst_rsv_ack", {7'd0, ReserveAck}, 8'h00);
    tick();
    Reset = 0;
    idle_inputs();
    for (int a = 0; a < 4; a++) begin
      RaddrA = 2'(a); RaddrB = 2'(3 - a);
      #1;
      check($sformatf("rst2_dataA_r%0d", a), DataOutA, 8'h00);
      check($sformatf("rst2_busyA_r%0d", a), {7'd0, BusyA}, 8'h00);
      check($sformatf("rst2_busyB_r%0d", 3 - a), {7'd0, BusyB}, 8'h00);
    end
    check("rst2_anybusy", {7'd0, AnyBusy}, 8'h00);

    // Zero-register instance: r0 is hardwired, r1 behaves normally
    z_WriteEn = 1; z_Waddr = 0; z_DataIn = 8'hAA; z_ReserveEn = 1; z_ReserveAddr = 0;
    z_RaddrA = 0;
    #1;
    check("z_r0_ack", {7'd0, z_ReserveAck}, 8'h00);
    check("z_r0_cycle_data", z_DataOutA, 8'h00);
    tick();
    z_WriteEn = 1; z_Waddr = 1; z_DataIn = 8'hAA; z_ReserveEn = 0; z_RaddrB = 1;
    #1;
    check("z_r0_data", z_DataOutA, 8'h00);
    check("z_r0_busy", {7'd0, z_BusyA}, 8'h00);
    check("z_anybusy", {7'd0, z_AnyBusy}, 8'h00);
    tick();
    z_WriteEn = 0;
    #1 check("z_r1_data", z_DataOutB, 8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
